uart_rx_cfg: RTL and testbench
==============================

# uart_rx_cfg

Configurable UART receiver and successor to the fixed 8N1 receiver. It supports 5–9 data bits, runtime-selectable parity (none/even/odd) and 1 or 2 stop bits. Each bit is decided by a 3-sample majority vote, and the block reports parity, framing and break errors. It sits between the baud-rate generator (oversampling tick) and the RX consumer (FIFO or host interface).

## Interface
- NBITS_DATA, 8, data bits per frame; legal 5..9.
- OVERSAMPLE, 16, i_tick_brg ticks per bit; even, ≥ 4.
- i_clk  in  1  system clock.
- i_reset  in  1  reset, synchronous, active-high.
- i_rx  in  1  serial line, asynchronous, idle high.
- i_tick_brg  in  1  oversampling strobe, one i_clk cycle wide.
- i_parity_mode  in  2  00 none, 01 even, 10 odd, 11 treated as none.
- i_two_stop  in  1  1 = two stop bits.
- o_data  out  NBITS_DATA  received word, LSB first on the line.
- o_rx_done  out  1  one-cycle pulse, frame complete.
- o_parity_err  out  1  parity mismatch in last frame.
- o_frame_err  out  1  a stop bit sampled low in last frame.
- o_break  out  1  break detected in last frame.

## Operation
- i_rx passes through a 2-flop synchronizer (rx_s), which resets to 1. All logic uses rx_s.
- Tick counter width is $clog2(OVERSAMPLE). Bit counter width is $clog2(NBITS_DATA)+1.
- States are IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
- IDLE:
  - A high-to-low transition of rx_s moves to START and clears the tick counter.
  - On that transition, i_parity_mode and i_two_stop are latched.
  - Changes to i_parity_mode or i_two_stop mid-frame are ignored.
- START:
  - At tick count OVERSAMPLE/2−1, rx_s is checked.
  - If rx_s is high, this is a false start: return to IDLE with no output change.
  - If rx_s is low, clear the tick counter and go to DATA.
- Sampling rule for every subsequent bit:
  - Samples are taken at tick counts OVERSAMPLE−3, −2 and −1.
  - The bit value is the majority of the three samples.
  - The bit is decided at count OVERSAMPLE−1, and the counter then wraps to 0.
- DATA:
  - Each decided bit shifts in MSB-side and right-shifts the buffer.
  - After NBITS_DATA bits, go to PARITY if parity is enabled, otherwise go to STOP.
- PARITY:
  - Expected parity bit is XOR(data) for even and ~XOR(data) for odd.
  - A pending error is set if the received bit differs from the expected bit.
- STOP:
  - Decide 1 or 2 stop bits according to the latched i_two_stop.
  - Pending frame error is set if any stop bit decides 0.
  - Pending break is set if all data bits, the parity bit (if present) and the first stop bit are all 0.
- Completion, at the last stop decision:
  - Register o_data ← buffer.
  - Register the three error flags from their pending values.
  - Pulse o_rx_done.
  - Next state is WAIT_HIGH if a frame error occurred, otherwise IDLE.
- WAIT_HIGH: stay until rx_s = 1, then go to IDLE. This prevents a held break from producing repeated frames.
- Output holding:
  - o_data and the flags hold until the next o_rx_done.
  - A false start, or reset before completion, never updates them.
- Reset (any state, including mid-frame):
  - State returns to IDLE, all counters and the buffer clear.
  - o_data = 0, o_rx_done = 0, all flags = 0, rx_s = 1.

## Timing
- o_rx_done is registered. It goes high for exactly one i_clk cycle, the cycle after the i_tick_brg that decides the last stop bit.
- o_data and the flags change in that same cycle.
- Latency from the falling edge on i_rx to o_rx_done:
  - 2 i_clk cycles (synchronizer), plus
  - OVERSAMPLE/2 + (NBITS_DATA + P + S)·OVERSAMPLE ticks, where P ∈ {0,1} and S ∈ {1,2}, plus
  - 1 i_clk cycle.
- Ticks are counted only when i_tick_brg = 1. Between ticks, state and counters hold.
- Earliest next frame: a new start edge is accepted in the first IDLE cycle after o_rx_done. Back-to-back frames with no idle gap are received correctly.
- A low glitch on i_rx shorter than OVERSAMPLE/2 ticks at the start bit is rejected.
- A single-sample glitch inside any bit is absorbed by the majority vote.

## Test plan
- 8N1, OVERSAMPLE=16, send 0xA5 → one o_rx_done pulse; o_data=0xA5; all flags 0; latency matches the formula.
- 8E1, send 0x3C with the parity bit forced to 1 → o_data=0x3C, o_parity_err=1, o_frame_err=0.
- NBITS_DATA=7, odd parity, two stop bits, second stop bit driven low → o_frame_err=1; FSM waits in WAIT_HIGH until the line returns high.
- i_rx low for 4 ticks, then high → no o_rx_done; FSM back in IDLE; o_data unchanged. Separately, a one-tick low glitch mid-bit in 0xFF → o_data=0xFF.
- Line held low for 20 bit times → exactly one o_rx_done with o_break=1, o_frame_err=1 and o_data=0x00. After the line goes high, a following 0x55 frame is received with all flags 0.
- Assert i_reset during DATA of a frame → all outputs 0 and state IDLE on the next cycle. The next full frame, 0x81, decodes correctly.

Source files
------------

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: 5..9 data bits, none/even/odd parity, 1 or 2 stop bits.
// Every bit after the start bit is decided by a 3-sample majority vote at the end of its window.
module uart_rx_cfg #(
  parameter int unsigned NBITS_DATA = 8,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_rx,
  input  logic                  i_tick_brg,
  input  logic [1:0]            i_parity_mode,
  input  logic                  i_two_stop,
  output logic [NBITS_DATA-1:0] o_data,
  output logic                  o_rx_done,
  output logic                  o_parity_err,
  output logic                  o_frame_err,
  output logic                  o_break
);

  localparam int unsigned TickW = $clog2(OVERSAMPLE);
  localparam int unsigned BitW  = $clog2(NBITS_DATA) + 1;

  localparam logic [TickW-1:0] TickHalf = TickW'(OVERSAMPLE / 2 - 1);
  localparam logic [TickW-1:0] TickS0   = TickW'(OVERSAMPLE - 3);
  localparam logic [TickW-1:0] TickS1   = TickW'(OVERSAMPLE - 2);
  localparam logic [TickW-1:0] TickLast = TickW'(OVERSAMPLE - 1);
  localparam logic [BitW-1:0]  LastBit  = BitW'(NBITS_DATA - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop,
    StWaitHigh
  } state_e;

  state_e                  state_q, state_d;
  logic                    rx_meta_q, rx_s_q, rx_prev_q;
  logic [TickW-1:0]        tick_q, tick_d;
  logic [BitW-1:0]         bit_q, bit_d;
  logic [NBITS_DATA-1:0]   buf_q, buf_d;
  logic [1:0]              samp_q, samp_d;
  logic                    par_en_q, par_en_d;
  logic                    par_odd_q, par_odd_d;
  logic                    two_stop_q, two_stop_d;
  logic                    pe_q, pe_d;
  logic                    fe_q, fe_d;
  logic                    zero_q, zero_d;
  logic [NBITS_DATA-1:0]   data_q, data_d;
  logic                    done_q, done_d;
  logic                    perr_q, perr_d;
  logic                    ferr_q, ferr_d;
  logic                    brk_q, brk_d;

  logic last_tick, bit_val, exp_par, zero_stop, fe_now, bit_state;

  always_comb begin
    state_d    = state_q;
    tick_d     = tick_q;
    bit_d      = bit_q;
    buf_d      = buf_q;
    samp_d     = samp_q;
    par_en_d   = par_en_q;
    par_odd_d  = par_odd_q;
    two_stop_d = two_stop_q;
    pe_d       = pe_q;
    fe_d       = fe_q;
    zero_d     = zero_q;
    data_d     = data_q;
    done_d     = 1'b0;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    brk_d      = brk_q;

    last_tick = (tick_q == TickLast);
    bit_val   = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s_q) | (samp_q[1] & rx_s_q);
    exp_par   = (^buf_q) ^ par_odd_q;
    zero_stop = zero_q & ~bit_val;
    fe_now    = fe_q | ~bit_val;
    bit_state = (state_q == StData) || (state_q == StParity) || (state_q == StStop);

    // Shared sampling window for every bit after the start bit
    if (i_tick_brg && bit_state) begin
      if (tick_q == TickS0) samp_d[0] = rx_s_q;
      if (tick_q == TickS1) samp_d[1] = rx_s_q;
      tick_d = last_tick ? '0 : tick_q + 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (rx_prev_q && !rx_s_q) begin
          state_d    = StStart;
          tick_d     = '0;
          bit_d      = '0;
          par_en_d   = (i_parity_mode == 2'b01) || (i_parity_mode == 2'b10);
          par_odd_d  = (i_parity_mode == 2'b10);
          two_stop_d = i_two_stop;
          pe_d       = 1'b0;
          fe_d       = 1'b0;
          zero_d     = 1'b1;
        end
      end
      StStart: begin
        if (i_tick_brg) begin
          if (tick_q == TickHalf) begin
            tick_d  = '0;
            state_d = rx_s_q ? StIdle : StData;
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end
      StData: begin
        if (i_tick_brg && last_tick) begin
          buf_d  = {bit_val, buf_q[NBITS_DATA-1:1]};
          zero_d = zero_stop;
          if (bit_q == LastBit) begin
            bit_d   = '0;
            state_d = par_en_q ? StParity : StStop;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      StParity: begin
        if (i_tick_brg && last_tick) begin
          pe_d    = (bit_val != exp_par);
          zero_d  = zero_stop;
          state_d = StStop;
        end
      end
      StStop: begin
        if (i_tick_brg && last_tick) begin
          fe_d = fe_now;
          // Break only looks through the first stop bit
          if (bit_q == '0) zero_d = zero_stop;
          if (two_stop_q && (bit_q == '0)) begin
            bit_d = 1'b1;
          end else begin
            data_d  = buf_q;
            done_d  = 1'b1;
            perr_d  = pe_q;
            ferr_d  = fe_now;
            brk_d   = (bit_q == '0) ? zero_stop : zero_q;
            state_d = fe_now ? StWaitHigh : StIdle;
          end
        end
      end
      StWaitHigh: begin
        if (rx_s_q) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      rx_meta_q  <= 1'b1;
      rx_s_q     <= 1'b1;
      rx_prev_q  <= 1'b1;
      state_q    <= StIdle;
      tick_q     <= '0;
      bit_q      <= '0;
      buf_q      <= '0;
      samp_q     <= '0;
      par_en_q   <= 1'b0;
      par_odd_q  <= 1'b0;
      two_stop_q <= 1'b0;
      pe_q       <= 1'b0;
      fe_q       <= 1'b0;
      zero_q     <= 1'b0;
      data_q     <= '0;
      done_q     <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      brk_q      <= 1'b0;
    end else begin
      rx_meta_q  <= i_rx;
      rx_s_q     <= rx_meta_q;
      rx_prev_q  <= rx_s_q;
      state_q    <= state_d;
      tick_q     <= tick_d;
      bit_q      <= bit_d;
      buf_q      <= buf_d;
      samp_q     <= samp_d;
      par_en_q   <= par_en_d;
      par_odd_q  <= par_odd_d;
      two_stop_q <= two_stop_d;
      pe_q       <= pe_d;
      fe_q       <= fe_d;
      zero_q     <= zero_d;
      data_q     <= data_d;
      done_q     <= done_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      brk_q      <= brk_d;
    end
  end

  assign o_data       = data_q;
  assign o_rx_done    = done_q;
  assign o_parity_err = perr_q;
  assign o_frame_err  = ferr_q;
  assign o_break      = brk_q;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Scoreboard bench for uart_rx_cfg: an 8-bit and a 7-bit instance, tick-aligned line driver,
// expected frames queued at stimulus time and checked by a monitor on every o_rx_done.
module tb_uart_rx_cfg;

  localparam int OS   = 16;
  localparam int TDIV = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, line, sel7, tick;
  logic [1:0] pmode;
  logic       two;
  logic       rx8, rx7;
  assign rx8 = sel7 ? 1'b1 : line;
  assign rx7 = sel7 ? line : 1'b1;

  logic [7:0] data8;
  logic [6:0] data7;
  logic done8, pe8, fe8, brk8, done7, pe7, fe7, brk7;

  uart_rx_cfg #(.NBITS_DATA(8), .OVERSAMPLE(OS)) dut8 (
    .i_clk(clk), .i_reset(rst), .i_rx(rx8), .i_tick_brg(tick), .i_parity_mode(pmode),
    .i_two_stop(two), .o_data(data8), .o_rx_done(done8), .o_parity_err(pe8),
    .o_frame_err(fe8), .o_break(brk8)
  );

  uart_rx_cfg #(.NBITS_DATA(7), .OVERSAMPLE(OS)) dut7 (
    .i_clk(clk), .i_reset(rst), .i_rx(rx7), .i_tick_brg(tick), .i_parity_mode(pmode),
    .i_two_stop(two), .o_data(data7), .o_rx_done(done7), .o_parity_err(pe7),
    .o_frame_err(fe7), .o_break(brk7)
  );

  typedef struct {
    logic [8:0] data;
    logic       pe;
    logic       fe;
    logic       brk;
    longint     cyc;
  } exp_t;

  exp_t   q8[$];
  exp_t   q7[$];
  int     n_tests = 0;
  int     n_fail  = 0;
  longint cyc     = 0;
  event   tick_ev;
  int     div     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // One tick every TDIV cycles; tick_ev marks the negedge right after a tick was consumed
  initial begin
    tick = 1'b0;
    forever begin
      @(negedge clk);
      if (tick) ->tick_ev;
      div  = (div + 1) % TDIV;
      tick = (div == 0);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_frame(input bit is7, input logic [8:0] d, input logic pe, input logic fe,
                             input logic brk);
    exp_t  e;
    string t;
    t = is7 ? "dut7" : "dut8";
    if ((is7 && q7.size() == 0) || (!is7 && q8.size() == 0)) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s unexpected_done: o_rx_done=1 at cycle %0d, expected no frame", t, cyc);
    end else begin
      if (is7) e = q7.pop_front();
      else e = q8.pop_front();
      chk({t, " data"}, 32'(d), 32'(e.data));
      chk({t, " parity_err"}, 32'(pe), 32'(e.pe));
      chk({t, " frame_err"}, 32'(fe), 32'(e.fe));
      chk({t, " break"}, 32'(brk), 32'(e.brk));
      chk({t, " latency_cycles"}, 32'(cyc), 32'(e.cyc));
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (done8) check_frame(1'b0, {1'b0, data8}, pe8, fe8, brk8);
        if (done7) check_frame(1'b1, {2'b00, data7}, pe7, fe7, brk7);
      end
    end
  end

  task automatic hold(input logic v, input int n);
    line = v;
    repeat (n) @(tick_ev);
  endtask

  // d must have bits above nbits cleared; last_stop drives the final stop bit
  task automatic send_frame(input logic [8:0] d, input int nbits, input logic [1:0] pm,
                            input logic ts, input logic flip_par, input logic last_stop,
                            input int glitch_bit, input logic [8:0] ed, input logic ep,
                            input logic ef, input logic eb);
    exp_t e;
    logic pen, pb, b;
    int   nt;
    pen = (pm == 2'b01) || (pm == 2'b10);
    pb  = (^d) ^ (pm == 2'b10) ^ flip_par;
    nt  = OS / 2 + (nbits + (pen ? 1 : 0) + (ts ? 2 : 1)) * OS;
    pmode = pm;
    two   = ts;
    e.data = ed; e.pe = ep; e.fe = ef; e.brk = eb;
    e.cyc  = cyc + longint'(TDIV * nt);
    if (sel7) q7.push_back(e);
    else q8.push_back(e);
    hold(1'b0, OS);
    // Mode inputs change mid-frame; the receiver must keep the latched values
    pmode = (pm == 2'b00) ? 2'b01 : 2'b00;
    two   = ~ts;
    for (int i = 0; i < nbits; i++) begin
      b = d[i];
      if (i == glitch_bit) begin
        hold(b, 5);
        hold(~b, 1);
        hold(b, OS - 6);
      end else begin
        hold(b, OS);
      end
    end
    if (pen) hold(pb, OS);
    if (ts) hold(1'b1, OS);
    hold(last_stop, OS);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    rst = 1'b1; line = 1'b1; sel7 = 1'b0; pmode = 2'b00; two = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset data8", 32'(data8), 32'h0);
    chk("reset done8", 32'(done8), 32'h0);
    chk("reset flags8", 32'({pe8, fe8, brk8}), 32'h0);
    chk("reset data7", 32'(data7), 32'h0);
    chk("reset flags7", 32'({done7, pe7, fe7, brk7}), 32'h0);
    hold(1'b1, 8);

    // 8N1 0xA5, 8E1 bad parity, 8O1 good parity
    send_frame(9'h0A5, 8, 2'b00, 1'b0, 1'b0, 1'b1, -1, 9'h0A5, 1'b0, 1'b0, 1'b0);
    hold(1'b1, 20);
    send_frame(9'h03C, 8, 2'b01, 1'b0, 1'b1, 1'b1, -1, 9'h03C, 1'b1, 1'b0, 1'b0);
    hold(1'b1, 20);
    send_frame(9'h03C, 8, 2'b10, 1'b0, 1'b0, 1'b1, -1, 9'h03C, 1'b0, 1'b0, 1'b0);
    hold(1'b1, 20);
    // Back-to-back 8N2 frames, no idle gap
    send_frame(9'h012, 8, 2'b00, 1'b1, 1'b0, 1'b1, -1, 9'h012, 1'b0, 1'b0, 1'b0);
    send_frame(9'h034, 8, 2'b00, 1'b1, 1'b0, 1'b1, -1, 9'h034, 1'b0, 1'b0, 1'b0);
    hold(1'b1, 20);

    // 7O2 with second stop low, line stays low afterwards, then a clean 7O2 frame
    sel7 = 1'b1;
    send_frame(9'h035, 7, 2'b10, 1'b1, 1'b0, 1'b0, -1, 9'h035, 1'b0, 1'b1, 1'b0);
    hold(1'b0, 3 * OS);
    hold(1'b1, 2 * OS);
    send_frame(9'h04B, 7, 2'b10, 1'b1, 1'b0, 1'b1, -1, 9'h04B, 1'b0, 1'b0, 1'b0);
    hold(1'b1, 20);
    sel7 = 1'b0;

    // False start: 4 ticks low
    hold(1'b0, 4);
    hold(1'b1, 3 * OS);
    chk("false_start data8_held", 32'(data8), 32'h34);

    // Single-tick glitch inside bit 3 of 0xFF
    send_frame(9'h0FF, 8, 2'b00, 1'b0, 1'b0, 1'b1, 3, 9'h0FF, 1'b0, 1'b0, 1'b0);
    hold(1'b1, 20);

    // Break: 20 bit times low, then 0x55
    pmode = 2'b00; two = 1'b0;
    e.data = 9'h000; e.pe = 1'b0; e.fe = 1'b1; e.brk = 1'b1;
    e.cyc  = cyc + longint'(TDIV * (OS / 2 + 9 * OS));
    q8.push_back(e);
    hold(1'b0, 20 * OS);
    hold(1'b1, 2 * OS);
    send_frame(9'h055, 8, 2'b00, 1'b0, 1'b0, 1'b1, -1, 9'h055, 1'b0, 1'b0, 1'b0);
    hold(1'b1, 20);

    // Reset during DATA, then 0x81
    hold(1'b0, OS);
    hold(1'b1, OS);
    hold(1'b0, OS);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst  = 1'b0;
    line = 1'b1;
    chk("midreset data8", 32'(data8), 32'h0);
    chk("midreset done8", 32'(done8), 32'h0);
    chk("midreset flags8", 32'({pe8, fe8, brk8}), 32'h0);
    hold(1'b1, 2 * OS);
    send_frame(9'h081, 8, 2'b00, 1'b0, 1'b0, 1'b1, -1, 9'h081, 1'b0, 1'b0, 1'b0);
    hold(1'b1, 2 * OS);

    for (int i = 0; i < 2000 && (q8.size() != 0 || q7.size() != 0); i++) @(negedge clk);
    chk("pending_frames", 32'(q8.size() + q7.size()), 32'h0);
    repeat (20) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
